// File: rtl/led_pkg.sv
// +--------------------------------------------------------------------------+
// | led_pkg : shared state encodings and defaults for the LED shift driver   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

package led_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LO   = 2'd1,
    ST_HI   = 2'd2,
    ST_DONE = 2'd3
  } led_state_e;

  localparam int c_DEFAULT_WIDTH = 16;
  localparam bit c_ACTIVE_LOW    = 1'b1;

  // Counter width for a modulus n, never narrower than one bit.
  function automatic int cnt_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/led_phase_tick.sv
// +--------------------------------------------------------------------------+
// | led_phase_tick : phase counter with terminal-count pulse at CLK_DIV-1    |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module led_phase_tick
  import led_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic i_clr,
  output logic o_tick
);

  localparam int              PW     = cnt_width(CLK_DIV);
  localparam logic [PW-1:0]   c_LAST = PW'(CLK_DIV - 1);

  logic [PW-1:0] r_phase;

  assign o_tick = (r_phase == c_LAST);

  // The tick always coincides with a state change upstream, so wrapping
  // here keeps the counter aligned to every new half-period.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_phase <= '0;
    end else if (i_clr || o_tick) begin
      r_phase <= '0;
    end else begin
      r_phase <= r_phase + 1'b1;
    end
  end

endmodule

`default_nettype wire

// File: rtl/led_shift_driver.sv
// +--------------------------------------------------------------------------+
// | led_shift_driver : serial LED chain feeder, MSB first, divided led_clk   |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module led_shift_driver
  import led_pkg::*;
#(
  parameter int WIDTH   = c_DEFAULT_WIDTH,
  parameter int CLK_DIV = 4,
  parameter bit INVERT  = c_ACTIVE_LOW
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_valid,
  output logic             in_ready,
  output logic             led_do,
  output logic             led_clk,
  output logic             led_clr,
  output logic             led_pen,
  output logic             frame_done
);

  localparam int            BW         = cnt_width(WIDTH);
  localparam logic [BW-1:0] c_LAST_BIT = BW'(WIDTH - 1);

  led_state_e       r_state;
  led_state_e       w_state_nxt;
  logic [WIDTH-2:0] r_shift;
  logic [WIDTH-2:0] w_shift_nxt;
  logic [BW-1:0]    r_bit_cnt;
  logic [BW-1:0]    w_bit_nxt;
  logic             r_led_clk;
  logic             w_clk_nxt;
  logic             r_led_do;
  logic             w_do_nxt;
  logic             r_led_clr;
  logic             r_led_pen;
  logic             w_pen_nxt;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_phase_clr;
  logic             w_tick;
  logic             w_ready;

  led_phase_tick #(
    .CLK_DIV (CLK_DIV)
  ) u_phase_tick (
    .clk    (clk),
    .reset  (reset),
    .i_clr  (w_phase_clr),
    .o_tick (w_tick)
  );

  // Ready only once the chain clear has been released after reset.
  assign w_ready    = (r_state == ST_IDLE) && r_led_clr;
  assign in_ready   = w_ready;
  assign led_do     = r_led_do;
  assign led_clk    = r_led_clk;
  assign led_clr    = r_led_clr;
  assign led_pen    = r_led_pen;
  assign frame_done = r_done;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state   <= ST_IDLE;
      r_shift   <= '0;
      r_bit_cnt <= '0;
      r_led_clk <= 1'b0;
      r_led_do  <= INVERT;
      r_led_clr <= 1'b0;
      r_led_pen <= 1'b0;
      r_done    <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_shift   <= w_shift_nxt;
      r_bit_cnt <= w_bit_nxt;
      r_led_clk <= w_clk_nxt;
      r_led_do  <= w_do_nxt;
      r_led_clr <= 1'b1;
      r_led_pen <= w_pen_nxt;
      r_done    <= w_done_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_shift_nxt = r_shift;
    w_bit_nxt   = r_bit_cnt;
    w_clk_nxt   = r_led_clk;
    w_do_nxt    = r_led_do;
    w_pen_nxt   = r_led_pen;
    w_done_nxt  = 1'b0;
    w_phase_clr = 1'b0;

    case (r_state)
      ST_IDLE: begin
        w_phase_clr = 1'b1;
        w_clk_nxt   = 1'b0;
        w_do_nxt    = INVERT;
        if (in_valid && w_ready) begin
          w_state_nxt = ST_LO;
          w_shift_nxt = in_data[WIDTH-2:0];
          w_do_nxt    = in_data[WIDTH-1] ^ INVERT;
          w_bit_nxt   = c_LAST_BIT;
        end
      end

      ST_LO: begin
        if (w_tick) begin
          w_state_nxt = ST_HI;
          w_clk_nxt   = 1'b1;
        end
      end

      // Data moves only on the falling edge, giving CLK_DIV cycles of
      // setup and hold around each rising edge.
      ST_HI: begin
        if (w_tick) begin
          w_clk_nxt = 1'b0;
          if (r_bit_cnt != '0) begin
            w_state_nxt = ST_LO;
            w_do_nxt    = r_shift[WIDTH-2] ^ INVERT;
            w_shift_nxt = r_shift << 1;
            w_bit_nxt   = r_bit_cnt - 1'b1;
          end else begin
            w_state_nxt = ST_DONE;
            w_do_nxt    = INVERT;
            w_done_nxt  = 1'b1;
            w_pen_nxt   = 1'b1;
          end
        end
      end

      ST_DONE: begin
        w_phase_clr = 1'b1;
        w_state_nxt = ST_IDLE;
      end

      default: begin
        w_phase_clr = 1'b1;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_led_shift_driver.sv
// +--------------------------------------------------------------------------+
// | tb_led_shift_driver : scoreboard bench, two configurations side by side  |
// | rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
`default_nettype none

module tb_led_shift_driver;

  logic        clk;
  logic        rst;
  logic [15:0] in_data    [2];
  logic        in_valid   [2];
  logic        in_ready   [2];
  logic        led_do     [2];
  logic        led_clk    [2];
  logic        led_clr    [2];
  logic        led_pen    [2];
  logic        frame_done [2];

  int total = 0;
  int bad   = 0;

  bit q0[$];
  bit q1[$];
  int rises [2];
  int cyc   [2];
  logic prev_clk [2];

  // Instance 0: WIDTH=16, CLK_DIV=2, active-low LEDs.
  led_shift_driver #(.WIDTH(16), .CLK_DIV(2), .INVERT(1'b1)) u_dut_a (
    .clk(clk), .reset(rst), .in_data(in_data[0]), .in_valid(in_valid[0]),
    .in_ready(in_ready[0]), .led_do(led_do[0]), .led_clk(led_clk[0]),
    .led_clr(led_clr[0]), .led_pen(led_pen[0]), .frame_done(frame_done[0])
  );

  // Instance 1: WIDTH=16, CLK_DIV=1, active-high LEDs.
  led_shift_driver #(.WIDTH(16), .CLK_DIV(1), .INVERT(1'b0)) u_dut_b (
    .clk(clk), .reset(rst), .in_data(in_data[1]), .in_valid(in_valid[1]),
    .in_ready(in_ready[1]), .led_do(led_do[1]), .led_clk(led_clk[1]),
    .led_clr(led_clr[1]), .led_pen(led_pen[1]), .frame_done(frame_done[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int div_of(input int d);
    return (d == 0) ? 2 : 1;
  endfunction

  function automatic bit inv_of(input int d);
    return (d == 0);
  endfunction

  function automatic void push_exp(input int d, input bit b);
    if (d == 0) q0.push_back(b);
    else        q1.push_back(b);
  endfunction

  function automatic bit pop_exp(input int d);
    bit b;
    if (d == 0) b = q0.pop_front();
    else        b = q1.pop_front();
    return b;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? q0.size() : q1.size();
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Sample each led_clk rising edge against the scoreboard and check its period.
  always @(negedge clk) begin
    for (int d = 0; d < 2; d++) begin
      if (rst) begin
        cyc[d] = 0;
      end else begin
        cyc[d]++;
        if (led_clk[d] === 1'b1 && prev_clk[d] === 1'b0) begin
          if (rises[d] > 0)
            chk($sformatf("period_d%0d_r%0d", d, rises[d]), cyc[d], 2 * div_of(d));
          cyc[d] = 0;
          rises[d]++;
          if (qsize(d) == 0)
            chk($sformatf("extra_bit_d%0d", d), 1, 0);
          else
            chk($sformatf("bit_d%0d_r%0d", d, rises[d]), led_do[d], pop_exp(d));
        end
      end
      prev_clk[d] = led_clk[d];
    end
  end

  // Called at a negedge with the DUT idle; returns at the first idle negedge after DONE.
  task automatic frame(input int d, input logic [15:0] w, input bit keep, input bit pen0,
                       input int inj_k, input logic [15:0] inj_w);
    int k;
    int expk;
    bit inv;
    logic [15:0] wv;
    wv   = w;
    inv  = inv_of(d);
    expk = 2 * div_of(d) * 16;
    chk($sformatf("ready_pre_%h", w), in_ready[d], 1);
    in_data[d]  = w;
    in_valid[d] = 1'b1;
    rises[d]    = 0;
    for (int i = 15; i >= 0; i--) push_exp(d, wv[i] ^ inv);
    @(posedge clk);
    @(negedge clk);
    k = 0;
    chk($sformatf("ready_busy_%h", w), in_ready[d], 0);
    chk($sformatf("first_bit_%h", w), led_do[d], wv[15] ^ inv);
    chk($sformatf("pen_start_%h", w), led_pen[d], pen0);
    if (!keep) in_valid[d] = 1'b0;
    while (frame_done[d] !== 1'b1 && k < expk + 8) begin
      @(negedge clk);
      k++;
      if (k == inj_k) begin
        in_data[d]  = inj_w;
        in_valid[d] = 1'b1;
      end
    end
    chk($sformatf("done_cycle_%h", w), k, expk);
    chk($sformatf("ready_in_done_%h", w), in_ready[d], 0);
    chk($sformatf("pen_done_%h", w), led_pen[d], 1);
    @(negedge clk);
    chk($sformatf("done_pulse_%h", w), frame_done[d], 0);
    chk($sformatf("ready_idle_%h", w), in_ready[d], 1);
    chk($sformatf("clk_idle_%h", w), led_clk[d], 0);
    chk($sformatf("do_idle_%h", w), led_do[d], inv);
    chk($sformatf("bits_left_%h", w), qsize(d), 0);
    chk($sformatf("rises_%h", w), rises[d], 16);
  endtask

  initial begin
    rst = 1'b1;
    for (int d = 0; d < 2; d++) begin
      in_data[d]  = '0;
      in_valid[d] = 1'b0;
      rises[d]    = 0;
      cyc[d]      = 0;
      prev_clk[d] = 1'b0;
    end

    repeat (5) @(negedge clk);
    chk("rst_clk", led_clk[0], 0);
    chk("rst_do_a", led_do[0], 1);
    chk("rst_do_b", led_do[1], 0);
    chk("rst_clr", led_clr[0], 0);
    chk("rst_pen", led_pen[0], 0);
    chk("rst_ready", in_ready[0], 0);
    chk("rst_done", frame_done[0], 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rel_clr", led_clr[0], 1);
    chk("rel_ready", in_ready[0], 1);
    chk("rel_ready_b", in_ready[1], 1);

    frame(0, 16'hA5C3, 1'b0, 1'b0, -1, 16'h0);
    frame(0, 16'h0001, 1'b1, 1'b1, -1, 16'h0);
    frame(0, 16'hFFFF, 1'b0, 1'b1, -1, 16'h0);
    frame(0, 16'h00FF, 1'b0, 1'b1, 13, 16'h1234);
    frame(0, 16'h1234, 1'b0, 1'b1, -1, 16'h0);

    // Abort a frame right after its 7th led_clk rising edge.
    in_data[0]  = 16'h3C3C;
    in_valid[0] = 1'b1;
    rises[0]    = 0;
    for (int i = 15; i >= 0; i--) push_exp(0, ~in_data[0][i]);
    @(posedge clk);
    @(negedge clk);
    in_valid[0] = 1'b0;
    repeat (26) @(negedge clk);
    #1;
    chk("abort_rises", rises[0], 7);
    rst = 1'b1;
    #1;
    chk("abort_clk", led_clk[0], 0);
    chk("abort_do", led_do[0], 1);
    chk("abort_clr", led_clr[0], 0);
    chk("abort_pen", led_pen[0], 0);
    chk("abort_ready", in_ready[0], 0);
    chk("abort_done", frame_done[0], 0);
    q0.delete();
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    frame(0, 16'hF00F, 1'b0, 1'b0, -1, 16'h0);

    frame(1, 16'h8001, 1'b0, 1'b0, -1, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/led_shift_driver.md
Name: led_shift_driver

Overview:
- Upstream feeder for the board's serial LED shift-register chain (LED data/clock/clear/enable pins).
- Accepts a WIDTH-bit LED word through a valid/ready handshake and shifts it out MSB first.
- Generates led_clk as a registered, divided clock (never a gated system clock), so the chain sees clean setup/hold around every rising edge.
- Provides blanking until the first complete frame and a one-cycle frame_done strobe.

Parameters:
WIDTH, 16, bits per frame (>=2)
CLK_DIV, 4, clk cycles per led_clk half-period (>=1)
INVERT, 1, 1 = LEDs active-low, so led_do = ~bit; 0 = led_do = bit

Ports:
clk  in  1  system clock (100 MHz domain)
reset  in  1  asynchronous, active-high reset
in_data  in  WIDTH  LED word, bit WIDTH-1 shifted first
in_valid  in  1  in_data valid
in_ready  out  1  block idle, can accept a word
led_do  out  1  serial data to chain
led_clk  out  1  shift clock to chain, data sampled on rising edge
led_clr  out  1  active-low chain clear
led_pen  out  1  chain output enable, 1 = display on
frame_done  out  1  one-cycle pulse when the last bit has been clocked

Behaviour:
- All outputs are registered; in_ready is decoded from state.
- Reset values (while reset=1):
  - led_clk=0, led_do=INVERT, led_clr=0, led_pen=0, frame_done=0, in_ready=0.
  - State IDLE, all counters 0.
- First clk edge after reset release: led_clr->1; in_ready=1 (IDLE).
- States: IDLE, LO, HI, DONE.
- IDLE:
  - led_clk=0, led_do=INVERT.
  - Handshake (in_valid & in_ready) at edge T0: capture in_data into a shift register, go to LO.
  - On the T0 edge: led_do = in_data[WIDTH-1]^INVERT; bit_cnt=WIDTH-1; phase_cnt=0.
- LO: led_clk=0 for CLK_DIV cycles, then go to HI; led_clk->1 on that edge.
- HI:
  - led_clk=1 for CLK_DIV cycles.
  - On exit edge: led_clk->0.
  - If bit_cnt!=0: shift left, led_do = next bit ^ INVERT (changes together with the falling edge), bit_cnt-1, go to LO.
  - If bit_cnt==0: go to DONE, led_do->INVERT.
- DONE: lasts exactly 1 cycle; frame_done=1, led_pen set 1 (sticky until reset); next edge to IDLE.
- Frame timing: in_ready is low for 2*CLK_DIV*WIDTH+1 cycles after T0. frame_done is asserted in the cycle T0+2*CLK_DIV*WIDTH+1.
- Data setup/hold to the chain: CLK_DIV cycles each side of every led_clk rising edge.
- in_valid while busy is ignored; in_data is only sampled on the handshake; no buffering.
- Back-to-back: in_valid held high gives a new T0 on the first IDLE cycle, so there is exactly one idle cycle between frames.
- Reset mid-frame: asynchronous return to reset values.
  - led_pen drops to 0, blanking the partial frame.
  - led_clr=0 clears the chain.
  - The partially sent word is discarded; the next frame after release is sent in full.
- Counters: phase_cnt width $clog2(CLK_DIV) (min 1), wraps to 0 on every state change; bit_cnt width $clog2(WIDTH).

Decomposition:
- Shared include/package led_pkg: state encodings (IDLE=0, LO=1, HI=2, DONE=3), the default WIDTH=16, and the active-low polarity constant.
- One natural sub-module: led_phase_tick. It holds phase_cnt and outputs a terminal-count pulse when phase_cnt==CLK_DIV-1, with a clear input. The FSM and shift register stay in led_shift_driver.

Test Plan:
- Reset held 5 cycles (WIDTH=16, CLK_DIV=2, INVERT=1) -> led_clk=0, led_do=1, led_clr=0, led_pen=0, in_ready=0. One edge after release -> led_clr=1, in_ready=1.
- Send 16'hA5C3 (CLK_DIV=2, INVERT=1) -> 16 led_clk rising edges sample 16'h5A3C MSB first. Each led_clk period is 4 cycles. frame_done pulses at T0+65, then led_pen=1 and in_ready=1.
- Hold in_valid high with 16'h0001 then 16'hFFFF -> second word accepted the first cycle in_ready=1 (T0+66). Sampled streams are ~0001 then ~FFFF. led_pen stays 1.
- Change in_data to 16'h1234 with in_valid=1 during bit 3 of frame 16'h00FF -> shifted stream unchanged (~00FF). 16'h1234 is accepted only after DONE.
- Assert reset after the 7th led_clk rising edge -> all outputs immediately go to reset values, led_pen=0. After release, a new 16'hF00F frame produces all 16 bits and frame_done.
- Configuration INVERT=0, CLK_DIV=1, send 16'h8001 -> sampled bits 1,0×14,1. led_clk toggles every cycle; frame_done at T0+33.
